seq_gen: RTL and testbench

Serial pattern transmitter; the driving end of the serial link consumed by seq_detect.
- Accepts a parallel word plus a bit length through a valid/ready handshake.
- Shifts the word out one bit per clock on data_out, MSB of the used field first.
- Supports optional idle gaps between frames, and back-to-back streaming when no gap is configured.
- Used as the stimulus source in front of seq_detect and as the on-chip test-pattern generator.

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_gen.sv | 111 +++++++++++
 tb/tb_seq_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial link (seq_gen transmitter / seq_detect receiver).
package seq_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_LEN_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/seq_gen.sv
// Serial pattern transmitter: accepts a word + length, shifts it out MSB-first.
module seq_gen
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned LEN_W    = DEF_LEN_W,
  parameter int unsigned GAP_CYC  = 0,
  parameter logic        IDLE_LVL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  output logic              data_out,
  output logic              out_active,
  output logic              frame_done
);

  localparam int unsigned       GAP_W    = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYC);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam bit                STREAM   = (GAP_CYC == 0);

  state_e            state;
  logic [DATA_W-1:0] shreg;
  logic [LEN_W-1:0]  cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic [LEN_W-1:0]  eff_len_c;
  logic [DATA_W-1:0] aligned_c;
  logic              last_c;
  logic              accept_c;

  // Clamp the requested length and left-justify the used field so the MSB sits at the top.
  always_comb begin
    eff_len_c = in_len;
    if (in_len == '0 || in_len > FULL_LEN) begin
      eff_len_c = FULL_LEN;
    end
    aligned_c = in_data << (FULL_LEN - eff_len_c);
  end

  // Last bit of the frame is on the wire when one bit remains.
  assign last_c   = (state == ST_SHIFT) && (cnt == LEN_ONE);
  assign in_ready = (state == ST_IDLE) || (last_c && STREAM);
  assign accept_c = in_valid && in_ready;

  // State, shifter, counters and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      gap_cnt    <= '0;
      data_out   <= IDLE_LVL;
      out_active <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_c;
      if (accept_c) begin
        state      <= ST_SHIFT;
        cnt        <= eff_len_c;
        shreg      <= aligned_c << 1;
        data_out   <= aligned_c[DATA_W-1];
        out_active <= 1'b1;
      end else begin
        case (state)
          ST_SHIFT: begin
            if (!last_c) begin
              cnt      <= cnt - LEN_ONE;
              shreg    <= shreg << 1;
              data_out <= shreg[DATA_W-1];
            end else begin
              cnt        <= '0;
              data_out   <= IDLE_LVL;
              out_active <= 1'b0;
              if (STREAM) begin
                state <= ST_IDLE;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= GAP_LOAD;
              end
            end
          end
          ST_GAP: begin
            if (gap_cnt == GAP_ONE) begin
              state   <= ST_IDLE;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt - GAP_ONE;
            end
          end
          ST_IDLE: begin
            data_out   <= IDLE_LVL;
            out_active <= 1'b0;
          end
          default: begin
            state      <= ST_IDLE;
            data_out   <= IDLE_LVL;
            out_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: one streaming instance and one with idle gaps.
module tb_seq_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned LW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %b expected %b at %0t", nm, inst, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int unsigned GC = (g == 0) ? 0 : 3;

    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [LW-1:0] in_len;
    logic          data_out;
    logic          out_active;
    logic          frame_done;

    // Scoreboard: one entry per expected bit, {is_last_bit, bit_value}.
    logic [1:0] q[$];
    int         gap_left  = 0;
    bit         prev_last = 1'b0;
    bit         in_rst    = 1'b1;
    bit         done      = 1'b0;

    seq_gen #(
      .DATA_W  (DW),
      .LEN_W   (LW),
      .GAP_CYC (GC),
      .IDLE_LVL(1'b0)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_len    (in_len),
      .data_out  (data_out),
      .out_active(out_active),
      .frame_done(frame_done)
    );

    function automatic void push_frame(input logic [DW-1:0] d, input logic [LW-1:0] l);
      int n;
      n = (l == 0 || int'(l) > int'(DW)) ? int'(DW) : int'(l);
      for (int i = n - 1; i >= 0; i--) q.push_back({i == 0, d[i]});
    endfunction

    // One cycle of offer; with hold, keep offering until taken (bounded).
    task automatic offer(input logic [DW-1:0] d, input logic [LW-1:0] l, input bit v, input bit hold);
      int   guard;
      bit   taken;
      logic rdy;
      guard = 0;
      taken = 1'b0;
      do begin
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_len   = l;
        rdy      = in_ready;
        @(posedge clk);
        if (v && rdy) begin
          push_frame(d, l);
          taken = 1'b1;
        end
        guard++;
      end while (hold && !taken && guard < 100);
      if (hold) chk("accept_timeout", g, taken, 1'b1);
    endtask

    task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_len   = LW'($urandom);
        @(posedge clk);
      end
    endtask

    // Reset in the middle of a frame: outputs clear at once and the frame is dropped.
    task automatic mid_reset();
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n  = 1'b0;
      in_rst = 1'b1;
      #1;
      chk("rst_data_out", g, data_out, 1'b0);
      chk("rst_out_active", g, out_active, 1'b0);
      chk("rst_frame_done", g, frame_done, 1'b0);
      chk("rst_in_ready", g, in_ready, 1'b1);
      q.delete();
      gap_left  = 0;
      prev_last = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      rst_n  = 1'b1;
      in_rst = 1'b0;
    endtask

    // Monitor: compare wire-level behaviour against the expected bit stream each cycle.
    always @(negedge clk) begin
      logic [1:0] e;
      logic       exp_ready;
      if (!in_rst) begin
        exp_ready = (q.size() == 0 && gap_left == 0) || (GC == 0 && q.size() == 1);
        chk("in_ready", g, in_ready, exp_ready);
        chk("out_active", g, out_active, q.size() != 0);
        chk("frame_done", g, frame_done, prev_last);
        prev_last = 1'b0;
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("data_out", g, data_out, e[0]);
          prev_last = e[1];
          if (e[1]) gap_left = int'(GC);
        end else begin
          chk("data_out_idle", g, data_out, 1'b0);
          if (gap_left > 0) gap_left--;
        end
      end
    end

    initial begin
      logic [DW-1:0] d;
      logic [LW-1:0] l;
      int            r;
      int            guard;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_len   = '0;
      #1;
      chk("por_data_out", g, data_out, 1'b0);
      chk("por_out_active", g, out_active, 1'b0);
      chk("por_frame_done", g, frame_done, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      rst_n  = 1'b1;
      in_rst = 1'b0;

      // Directed frames: single, back-to-back pair, clamped lengths, short pair.
      offer(16'h000B, LW'(4), 1'b1, 1'b1);
      idle(4);
      offer(16'h000B, LW'(4), 1'b1, 1'b1);
      offer(16'h0006, LW'(4), 1'b1, 1'b1);
      offer(16'h8001, LW'(0), 1'b1, 1'b1);
      offer(16'h8001, LW'(20), 1'b1, 1'b1);
      offer(16'h0005, LW'(3), 1'b1, 1'b1);
      offer(16'h0005, LW'(3), 1'b1, 1'b1);
      idle(6);
      offer(16'h00A5, LW'(8), 1'b1, 1'b1);
      mid_reset();
      offer(16'h0033, LW'(6), 1'b1, 1'b1);
      idle(2);

      // Random offers; data and length change every cycle, including while not ready.
      for (int k = 0; k < 1500; k++) begin
        d = DW'($urandom);
        r = int'($urandom_range(0, 9));
        if (r == 0)      l = '0;
        else if (r == 1) l = LW'($urandom_range(17, 31));
        else             l = LW'($urandom_range(1, 16));
        offer(d, l, $urandom_range(0, 2) != 0, 1'b0);
      end

      idle(1);
      guard = 0;
      while ((q.size() != 0 || gap_left != 0) && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      chk("drain", g, q.size() == 0, 1'b1);
      idle(3);
      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (h[0].done && h[1].done);
      repeat (60000) @(posedge clk);
    join_any
    disable fork;
    chk("completion", 0, h[0].done && h[1].done, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
